bidir_bus_ctrl: RTL and testbench

//  Owns the direction of one shared tri-state bus: drives oe/in of the bidir_buf instance and

---
 rtl/bidir_bus_ctrl_if.sv | 38 +++
 rtl/bidir_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bidir_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bidir_bus_ctrl_if.sv
// Bus-side signal bundle for bidir_bus_ctrl.
// slave  : the controller's view (requests in, grants/bus drive out).
// master : the environment's view (requesters, external device, buffer).
//
// Handshake: a local beat is transferred on a rising clk edge where reqN_valid
// and reqN_ready are both 1. A requester holds valid and data steady until it
// sees ready. Ready is only asserted for the granted requester during DRIVE.
interface bidir_bus_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ext_req;
  logic             ext_gnt;
  logic             oe;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] bus_in;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic [1:0]       state_dbg;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, ext_req, bus_in,
    output req0_ready, req1_ready, ext_gnt, oe, bus_out, rx_valid, rx_data,
           busy, state_dbg
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, ext_req, bus_in,
    input  req0_ready, req1_ready, ext_gnt, oe, bus_out, rx_valid, rx_data,
           busy, state_dbg
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Direction owner for one shared tri-state bus.
// Two local requesters share the outbound direction, one external device
// owns the inbound direction; every tenure is followed by TA_CYCLES idle
// turnaround cycles plus one IDLE decision cycle so owners never overlap.
// Optional macro ARB_RR_EN: round-robin between the local requesters
// (default: fixed priority, req0 over req1).
// state_dbg: 0=IDLE 1=DRIVE 2=RECV 3=TURN.
module bidir_bus_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TA_CYCLES = 1,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  bidir_bus_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RECV  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(TA_CYCLES + 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [TW-1:0]    ta_cnt;
  logic             gnt_sel;
  logic             gnt_sel_next;
  logic             last_ext;
  logic             last_ext_next;
  logic             oe_q;
  logic             ext_gnt_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             any_local;
  logic             granted_valid;
  logic             beat;
  logic             capture;
  logic             burst_end;
  logic             local_pick;
`ifdef ARB_RR_EN
  logic             last_local;
`endif

  assign any_local     = bus.req0_valid | bus.req1_valid;
  assign granted_valid = gnt_sel ? bus.req1_valid : bus.req0_valid;
  assign beat          = (state == DRIVE) & granted_valid;
  assign capture       = (state == RECV) & bus.ext_req;
  assign burst_end     = (count == CW'(BURST_MAX - 1));

  // Local arbitration: which requester (0/1) would win a grant this cycle.
  always_comb begin
    local_pick = 1'b0;
`ifdef ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      local_pick = ~last_local;
    end else begin
      local_pick = ~bus.req0_valid;
    end
`else
    local_pick = ~bus.req0_valid;
`endif
  end

  // State register plus registered bus-direction and receive datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt_sel    <= 1'b0;
      last_ext   <= 1'b0;
      count      <= '0;
      ta_cnt     <= '0;
      oe_q       <= 1'b0;
      ext_gnt_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef ARB_RR_EN
      last_local <= 1'b1;
`endif
    end else begin
      state      <= state_next;
      gnt_sel    <= gnt_sel_next;
      last_ext   <= last_ext_next;
      oe_q       <= (state_next == DRIVE);
      ext_gnt_q  <= (state_next == RECV);
      rx_valid_q <= capture;
      if (capture) begin
        rx_data_q <= bus.bus_in;
      end
      if (state == TURN) begin
        count  <= '0;
        ta_cnt <= ta_cnt + TW'(1);
      end else begin
        ta_cnt <= '0;
        if (beat || capture) begin
          count <= count + CW'(1);
        end
      end
`ifdef ARB_RR_EN
      if (state == IDLE && state_next == DRIVE) begin
        last_local <= local_pick;
      end
`endif
    end
  end

  // Next-state decision, grant selection and ext/local alternation.
  always_comb begin
    state_next    = state;
    gnt_sel_next  = gnt_sel;
    last_ext_next = last_ext;
    case (state)
      IDLE: begin
        if (bus.ext_req && (!last_ext || !any_local)) begin
          state_next    = RECV;
          last_ext_next = 1'b1;
        end else if (any_local) begin
          state_next    = DRIVE;
          gnt_sel_next  = local_pick;
          last_ext_next = 1'b0;
        end
      end
      DRIVE: begin
        if (!granted_valid || burst_end) begin
          state_next = TURN;
        end
      end
      RECV: begin
        if (!bus.ext_req || burst_end) begin
          state_next = TURN;
        end
      end
      TURN: begin
        if (ta_cnt == TW'(TA_CYCLES - 1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: ready and the outbound data mux follow the granted requester.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.bus_out    = '0;
    if (state == DRIVE) begin
      bus.req0_ready = ~gnt_sel & bus.req0_valid;
      bus.req1_ready = gnt_sel & bus.req1_valid;
      bus.bus_out    = gnt_sel ? bus.req1_data : bus.req0_data;
    end
    bus.busy      = (state != IDLE);
    bus.state_dbg = state;
    bus.oe        = oe_q;
    bus.ext_gnt   = ext_gnt_q;
    bus.rx_valid  = rx_valid_q;
    bus.rx_data   = rx_data_q;
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl (WIDTH=8, TA_CYCLES=1, BURST_MAX=4).
module tb_bidir_bus_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bidir_bus_ctrl_if #(.WIDTH(8)) bus_if ();

  bidir_bus_ctrl #(
    .WIDTH(8),
    .TA_CYCLES(1),
    .BURST_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_all(input logic v);
    bus_if.req0_valid = v;
    bus_if.req1_valid = v;
    bus_if.ext_req    = v;
    bus_if.req0_data  = {8{v}};
    bus_if.req1_data  = {8{v}};
    bus_if.bus_in     = {8{v}};
  endtask

  // bus-level invariants: no overlap, >= TA_CYCLES+1 released cycles between tenures
  initial begin
    int  idle_run;
    bit  in_ten;
    bit  seen;
    idle_run = 0;
    in_ten   = 0;
    seen     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle_run = 0;
        in_ten   = 0;
        seen     = 0;
      end else begin
        chk("no_overlap", {31'd0, bus_if.oe & bus_if.ext_gnt}, 32'd0);
        if (bus_if.oe || bus_if.ext_gnt) begin
          if (!in_ten) begin
            if (seen) chk("turn_gap", {31'd0, idle_run >= 2}, 32'd1);
            seen = 1;
          end
          in_ten   = 1;
          idle_run = 0;
        end else begin
          in_ten = 0;
          idle_run++;
        end
      end
    end
  end

  logic [7:0] t_data  [12];
  logic       t_valid [12];
  logic       t_oe    [12];
  logic       t_rdy   [12];
  logic [7:0] t_bus   [12];
  int         got_q[$];
  int         exp_ten [4];

  initial begin
    total = 0;
    bad   = 0;

    // reset with every input high
    rst = 1'b1;
    drive_all(1'b1);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_oe",       {31'd0, bus_if.oe},         32'd0);
    chk("rst_ext_gnt",  {31'd0, bus_if.ext_gnt},    32'd0);
    chk("rst_ready0",   {31'd0, bus_if.req0_ready}, 32'd0);
    chk("rst_ready1",   {31'd0, bus_if.req1_ready}, 32'd0);
    chk("rst_bus_out",  {24'd0, bus_if.bus_out},    32'd0);
    chk("rst_rx_valid", {31'd0, bus_if.rx_valid},   32'd0);
    chk("rst_rx_data",  {24'd0, bus_if.rx_data},    32'd0);
    chk("rst_busy",     {31'd0, bus_if.busy},       32'd0);
    cyc();
    rst = 1'b0;
    drive_all(1'b0);

    // single beat from req0
    cyc();
    bus_if.req0_valid = 1'b1;
    bus_if.req0_data  = 8'd10;
    #1;
    chk("one_idle_oe", {31'd0, bus_if.oe}, 32'd0);
    cyc();
    #1;
    chk("one_oe",      {31'd0, bus_if.oe},         32'd1);
    chk("one_bus_out", {24'd0, bus_if.bus_out},    32'd10);
    chk("one_ready0",  {31'd0, bus_if.req0_ready}, 32'd1);
    chk("one_ready1",  {31'd0, bus_if.req1_ready}, 32'd0);
    cyc();
    bus_if.req0_valid = 1'b0;
    #1;
    chk("one_tail_oe",    {31'd0, bus_if.oe},         32'd1);
    chk("one_tail_ready", {31'd0, bus_if.req0_ready}, 32'd0);
    cyc();
    #1;
    chk("one_turn_oe",    {31'd0, bus_if.oe},        32'd0);
    chk("one_turn_state", {30'd0, bus_if.state_dbg}, 32'd3);
    chk("one_turn_busy",  {31'd0, bus_if.busy},      32'd1);
    cyc();
    #1;
    chk("one_idle_busy",  {31'd0, bus_if.busy},      32'd0);

    // six-byte stream from req0: burst of 4, gap, burst of 2
    t_data  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd6, 8'h77, 8'd0, 8'd0};
    t_valid = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    t_oe    = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    t_rdy   = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    t_bus   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd5, 8'd6, 8'h77, 8'd0, 8'd0};
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      bus_if.req0_valid = t_valid[k];
      bus_if.req0_data  = t_data[k];
      #1;
      chk($sformatf("burst_oe_%0d", k),      {31'd0, bus_if.oe},         {31'd0, t_oe[k]});
      chk($sformatf("burst_ready_%0d", k),   {31'd0, bus_if.req0_ready}, {31'd0, t_rdy[k]});
      chk($sformatf("burst_bus_out_%0d", k), {24'd0, bus_if.bus_out},    {24'd0, t_bus[k]});
    end

    // inbound: two captures of 110 and 120
    cyc();
    bus_if.ext_req = 1'b1;
    #1;
    chk("rx_idle_gnt", {31'd0, bus_if.ext_gnt}, 32'd0);
    cyc();
    bus_if.bus_in = 8'd110;
    #1;
    chk("rx_gnt_0",   {31'd0, bus_if.ext_gnt},  32'd1);
    chk("rx_oe_0",    {31'd0, bus_if.oe},       32'd0);
    chk("rx_valid_0", {31'd0, bus_if.rx_valid}, 32'd0);
    cyc();
    bus_if.bus_in = 8'd120;
    #1;
    chk("rx_gnt_1",   {31'd0, bus_if.ext_gnt},  32'd1);
    chk("rx_valid_1", {31'd0, bus_if.rx_valid}, 32'd1);
    chk("rx_data_1",  {24'd0, bus_if.rx_data},  32'd110);
    cyc();
    bus_if.ext_req = 1'b0;
    bus_if.bus_in  = 8'd0;
    #1;
    chk("rx_gnt_2",   {31'd0, bus_if.ext_gnt},  32'd1);
    chk("rx_valid_2", {31'd0, bus_if.rx_valid}, 32'd1);
    chk("rx_data_2",  {24'd0, bus_if.rx_data},  32'd120);
    chk("rx_oe_2",    {31'd0, bus_if.oe},       32'd0);
    cyc();
    #1;
    chk("rx_turn_gnt",   {31'd0, bus_if.ext_gnt},  32'd0);
    chk("rx_turn_valid", {31'd0, bus_if.rx_valid}, 32'd0);
    chk("rx_turn_data",  {24'd0, bus_if.rx_data},  32'd120);
    cyc();
    #1;
    chk("rx_idle_busy",  {31'd0, bus_if.busy},     32'd0);

    // tenure order with all three requesters held from reset
    cyc();
    rst = 1'b1;
    drive_all(1'b0);
    cyc();
    rst = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_data  = 8'hA0;
    bus_if.req1_valid = 1'b1;
    bus_if.req1_data  = 8'hB0;
    bus_if.ext_req    = 1'b1;
    bus_if.bus_in     = 8'h55;
    begin
      logic prev_oe;
      logic prev_gnt;
      prev_oe  = 1'b0;
      prev_gnt = 1'b0;
      for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
        cyc();
        #1;
        if (bus_if.ext_gnt && !prev_gnt) got_q.push_back(2);
        if (bus_if.oe && !prev_oe) got_q.push_back(bus_if.req1_ready ? 1 : 0);
        prev_oe  = bus_if.oe;
        prev_gnt = bus_if.ext_gnt;
      end
    end
`ifdef ARB_RR_EN
    exp_ten = '{2, 0, 2, 1};
`else
    exp_ten = '{2, 0, 2, 0};
`endif
    chk("tenure_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("tenure_%0d", i), got_q[i], exp_ten[i]);
      end
    end

    // reset in the middle of a drive burst
    cyc();
    rst = 1'b1;
    drive_all(1'b0);
    cyc();
    rst = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_data  = 8'h3C;
    cyc();
    cyc();
    #1;
    chk("mid_pre_oe", {31'd0, bus_if.oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_oe",      {31'd0, bus_if.oe},         32'd0);
    chk("mid_busy",    {31'd0, bus_if.busy},       32'd0);
    chk("mid_ready0",  {31'd0, bus_if.req0_ready}, 32'd0);
    chk("mid_bus_out", {24'd0, bus_if.bus_out},    32'd0);
    chk("mid_ext_gnt", {31'd0, bus_if.ext_gnt},    32'd0);
    cyc();
    rst = 1'b0;
    drive_all(1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
